// File: rtl/hmc_rx_axis_master.sv
// HMC RX-side AXI4-Stream master: buffers per-cycle FLIT words in a small FIFO and
// presents them first-word-fall-through with FLIT masks packed into TUSER.
module hmc_rx_axis_master #(
  parameter int FPW            = 4,
  parameter int FLIT_WIDTH     = 128,
  parameter int DWIDTH         = FPW * FLIT_WIDTH,
  parameter int NUM_DATA_BYTES = DWIDTH / 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int AF_THRESHOLD   = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [FPW-1:0]                in_flit_valid,
  input  logic [FPW-1:0]                in_flit_hdr,
  input  logic [FPW-1:0]                in_flit_tail,
  output logic                          in_almost_full,
  output logic                          m_axis_rx_TVALID,
  input  logic                          m_axis_rx_TREADY,
  output logic [DWIDTH-1:0]             m_axis_rx_TDATA,
  output logic [NUM_DATA_BYTES-1:0]     m_axis_rx_TUSER,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = 3 * FPW;

  logic [DWIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [UW-1:0]     user_mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic              valid_r;
  logic              af_r;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;

  logic [FPW-1:0]    hdr_s;
  logic [FPW-1:0]    tail_s;
  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              drop_s;

  // Input sanitising and push/pop/accept decisions; a full queue still accepts when it pops.
  always_comb begin
    hdr_s       = in_flit_hdr & in_flit_valid;
    tail_s      = in_flit_tail & in_flit_valid;
    push_s      = in_valid & (|in_flit_valid);
    pop_s       = valid_r & m_axis_rx_TREADY;
    accept_s    = push_s & ((count_r < CW'(FIFO_DEPTH)) | pop_s);
    drop_s      = push_s & ~accept_s;
    count_nxt_s = count_r;
    if (accept_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !accept_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Queue control and status registers; valid/almost-full are registered copies of the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      af_r       <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CW'(0));
      af_r    <= (count_nxt_s >= CW'(AF_THRESHOLD));
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) begin
          drop_cnt_r <= drop_cnt_r + 16'd1;
        end
      end
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      data_mem_r[wr_ptr_r] <= in_data;
      user_mem_r[wr_ptr_r] <= {tail_s, hdr_s, in_flit_valid};
    end
  end

  // Stream view of the head entry, forced to zero whenever nothing is presented.
  always_comb begin
    if (valid_r) begin
      m_axis_rx_TDATA = data_mem_r[rd_ptr_r];
      m_axis_rx_TUSER = NUM_DATA_BYTES'(user_mem_r[rd_ptr_r]);
    end else begin
      m_axis_rx_TDATA = '0;
      m_axis_rx_TUSER = '0;
    end
  end

  assign m_axis_rx_TVALID = valid_r;
  assign in_almost_full   = af_r;
  assign fill_level       = count_r;
  assign overflow         = overflow_r;
  assign drop_cnt         = drop_cnt_r;

endmodule

// File: tb/tb_hmc_rx_axis_master.sv
// Scoreboard bench for hmc_rx_axis_master: expected words are queued as they are
// driven and compared against the stream as the DUT presents them.
module tb_hmc_rx_axis_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [511:0] in_data = '0;
  logic [3:0]   in_flit_valid = 4'd0;
  logic [3:0]   in_flit_hdr = 4'd0;
  logic [3:0]   in_flit_tail = 4'd0;
  logic         in_almost_full;
  logic         tvalid;
  logic         tready = 1'b0;
  logic [511:0] tdata;
  logic [63:0]  tuser;
  logic [3:0]   fill_level;
  logic         overflow;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [575:0] sb[$];
  logic [15:0]  m_drops = 16'd0;

  hmc_rx_axis_master dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_flit_valid(in_flit_valid), .in_flit_hdr(in_flit_hdr), .in_flit_tail(in_flit_tail),
    .in_almost_full(in_almost_full), .m_axis_rx_TVALID(tvalid), .m_axis_rx_TREADY(tready),
    .m_axis_rx_TDATA(tdata), .m_axis_rx_TUSER(tuser), .fill_level(fill_level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic set_word(input logic [511:0] d, input logic [3:0] v,
                          input logic [3:0] h, input logic [3:0] t);
    in_valid = 1'b1; in_data = d; in_flit_valid = v; in_flit_hdr = h; in_flit_tail = t;
  endtask

  // Advance one clock and update the scoreboard from the inputs that edge sampled.
  task automatic step();
    bit pop_m, push_m, acc_m;
    logic [63:0] u;
    pop_m  = (sb.size() != 0) && tready;
    push_m = in_valid && (|in_flit_valid);
    acc_m  = push_m && ((sb.size() < 8) || pop_m);
    u = {52'd0, in_flit_tail & in_flit_valid, in_flit_hdr & in_flit_valid, in_flit_valid};
    @(posedge clk); #1;
    if (rst) begin
      sb.delete();
      m_drops = 16'd0;
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (acc_m) sb.push_back({in_data, u});
      else if (push_m && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
    checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
    checks++; if (in_almost_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got af=%b ovf=%b exp 0 0", in_almost_full, overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drops got %0d exp 0", drop_cnt); end
    checks++; if (tdata !== 512'd0 || tuser !== 64'd0) begin errors++; $display("FAIL reset_data got tuser=%h exp 0", tuser); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [511:0] d;
    d = rand_word();
    tready = 1'b1;
    set_word(d, 4'b0011, 4'b0001, 4'b0010);
    step();
    in_valid = 1'b0;
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %b exp 1", tvalid); end
    checks++; if (tdata !== d) begin errors++; $display("FAIL single_tdata got %h exp %h", tdata, d); end
    checks++; if (tuser !== 64'h213) begin errors++; $display("FAIL single_tuser got %h exp 213", tuser); end
    step();
    checks++; if (tvalid !== 1'b0 || tdata !== 512'd0 || tuser !== 64'd0) begin errors++; $display("FAIL single_idle got tvalid=%b tuser=%h exp 0 0", tvalid, tuser); end
  endtask

  task automatic test_backpressure();
    logic [511:0] d [9];
    int lvl;
    tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d[i] = rand_word();
      set_word(d[i], 4'b1111, 4'b0001, 4'b1000);
      step();
      lvl = (i + 1 > 8) ? 8 : i + 1;
      checks++; if (in_almost_full !== (lvl >= 6)) begin errors++; $display("FAIL bp_af word %0d got %b exp %b", i, in_almost_full, (lvl >= 6)); end
      checks++; if (tdata !== d[0]) begin errors++; $display("FAIL bp_hold word %0d got %h exp %h", i, tdata, d[0]); end
    end
    in_valid = 1'b0;
    checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL bp_fill got %0d exp 8", fill_level); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop got ovf=%b cnt=%0d exp 1 1", overflow, drop_cnt); end
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== d[i]) begin errors++; $display("FAIL bp_drain word %0d got v=%b %h exp %h", i, tvalid, tdata, d[i]); end
      checks++; if (sb.size() == 0 || {tdata, tuser} !== sb[0]) begin errors++; $display("FAIL bp_sb word %0d got %h", i, tuser); end
      step();
    end
    checks++; if (fill_level !== 4'd0 || tvalid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL bp_empty got fill=%0d v=%b ovf=%b exp 0 0 1", fill_level, tvalid, overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [511:0] e [9];
    tready = 1'b0;
    for (int i = 0; i < 9; i++) e[i] = rand_word();
    for (int i = 0; i < 8; i++) begin
      set_word(e[i], 4'b0101, 4'b0100, 4'b0001);
      step();
    end
    set_word(e[8], 4'b1000, 4'b1000, 4'b1000);
    tready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL fpp_fill got %0d exp 8", fill_level); end
    checks++; if (drop_cnt !== m_drops) begin errors++; $display("FAIL fpp_drops got %0d exp %0d", drop_cnt, m_drops); end
    for (int i = 1; i < 9; i++) begin
      checks++; if (tvalid !== 1'b1 || sb.size() == 0 || {tdata, tuser} !== sb[0] || tdata !== e[i]) begin errors++; $display("FAIL fpp_drain word %0d got %h exp %h", i, tdata, e[i]); end
      step();
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b exp 0", tvalid); end
  endtask

  task automatic test_sanitise();
    logic [511:0] d;
    d = rand_word();
    tready = 1'b0;
    set_word(d, 4'b0001, 4'b1111, 4'b1000);
    step();
    set_word(rand_word(), 4'b0000, 4'b1111, 4'b1111);
    step();
    in_valid = 1'b0;
    checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL san_fill got %0d exp 1", fill_level); end
    checks++; if (tuser !== 64'h011 || tdata !== d) begin errors++; $display("FAIL san_tuser got %h exp 011", tuser); end
    checks++; if (drop_cnt !== m_drops) begin errors++; $display("FAIL san_drops got %0d exp %0d", drop_cnt, m_drops); end
    tready = 1'b1;
    step();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL san_empty_word got %b exp 0", tvalid); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_word(rand_word(), 4'b1111, 4'b0001, 4'b1000);
      step();
    end
    in_valid = 1'b0;
    checks++; if (fill_level !== 4'd5) begin errors++; $display("FAIL rm_fill got %0d exp 5", fill_level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (tvalid !== 1'b0 || fill_level !== 4'd0) begin errors++; $display("FAIL rm_clear got v=%b fill=%0d exp 0 0", tvalid, fill_level); end
    checks++; if (in_almost_full !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_flags got af=%b ovf=%b cnt=%0d exp 0 0 0", in_almost_full, overflow, drop_cnt); end
    d = rand_word();
    tready = 1'b1;
    set_word(d, 4'b0011, 4'b0011, 4'b0010);
    step();
    in_valid = 1'b0;
    checks++; if (tvalid !== 1'b1 || tdata !== d || tuser !== 64'h233) begin errors++; $display("FAIL rm_new got %h exp %h", tdata, d); end
    step();
    checks++; if (tvalid !== 1'b0 || fill_level !== 4'd0) begin errors++; $display("FAIL rm_stale got v=%b fill=%0d exp 0 0", tvalid, fill_level); end
  endtask

  task automatic test_saturation();
    logic [511:0] d;
    d = rand_word();
    tready = 1'b0;
    set_word(d, 4'b1111, 4'b0000, 4'b0000);
    for (int n = 0; n < 65544; n++) begin
      step();
      if (n == 1007) begin
        checks++; if (drop_cnt !== 16'd1000) begin errors++; $display("FAIL sat_mid got %0d exp 1000", drop_cnt); end
      end
      if (n == 65542) begin
        checks++; if (drop_cnt !== m_drops) begin errors++; $display("FAIL sat_edge got %0d exp %0d", drop_cnt, m_drops); end
      end
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h exp FFFF", drop_cnt); end
    checks++; if (overflow !== 1'b1 || fill_level !== 4'd8 || tdata !== d) begin errors++; $display("FAIL sat_state got ovf=%b fill=%0d exp 1 8", overflow, fill_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_push_pop();
    test_sanitise();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
